bram_port_arbiter: RTL and testbench

- Shares the single-port record BRAM (1024 x 8) between up to N_REQ byte-wide requesters: Ethernet RX payload loader, checksum engine, TX reply reader.
- Round-robin grant with burst ownership and a fairness cap.
- Drives the BRAM port directly and returns read data with per-requester valid strobes.
- Sits between the packet-handling FSMs and the record_ram instance.

---
 rtl/mhp_pkg.sv | 12 +
 rtl/rr_pick.sv | 33 +++
 rtl/bram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mhp_pkg.sv
// Shared types and record-RAM geometry for the packet-handling datapath.
package mhp_pkg;

  localparam int BRAM_ADDR_W = 10;
  localparam int BRAM_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    cand     = 0;
    cand_idx = '0;
    pick     = '0;
    idx      = '0;
    any      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand     = (int'(ptr) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any            = 1'b1;
        idx            = cand_idx;
        pick[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin owner arbitration of the single-port record BRAM with burst ownership
// and a fairness cap; read data is returned with per-requester valid strobes.
module bram_port_arbiter
  import mhp_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = BRAM_ADDR_W,
  parameter int DATA_W    = BRAM_DATA_W,
  parameter int MAX_BURST = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_lock,
  input  logic [N_REQ-1:0]         i_we,
  input  logic [N_REQ*ADDR_W-1:0]  i_addr,
  input  logic [N_REQ*DATA_W-1:0]  i_wdata,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_rvalid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_busy,
  output logic                     o_ram_en,
  output logic                     o_ram_we,
  output logic [ADDR_W-1:0]        o_ram_addr,
  output logic [DATA_W-1:0]        o_ram_wdata,
  input  logic [DATA_W-1:0]        i_ram_rdata
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [7:0]       burst_cnt;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rvalid_p1;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic [N_REQ-1:0] owner_mask;
  logic             access;
  logic             others_req;
  logic             at_cap;
  logic             force_rel;
  logic             release_own;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req  (i_req),
    .ptr  (rr_ptr),
    .pick (pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
  end

  assign access     = (state == OWN) && i_req[owner];
  assign others_req = |(i_req & ~owner_mask);
  // The cap counts the access being made this cycle, hence count+1.
  assign at_cap      = ({1'b0, burst_cnt} + 9'd1) >= 9'(MAX_BURST);
  assign force_rel   = access && at_cap && others_req;
  assign release_own = (!i_req[owner] && !i_lock[owner]) || force_rel;
  assign next_ptr    = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

  // Port stage: owner's slice drives the BRAM in the cycle it strobes req.
  assign o_ram_en    = access;
  assign o_ram_we    = access && i_we[owner];
  assign o_ram_addr  = access ? i_addr[int'(owner)*ADDR_W +: ADDR_W] : '0;
  assign o_ram_wdata = access ? i_wdata[int'(owner)*DATA_W +: DATA_W] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      gnt       <= '0;
      rvalid_p1 <= '0;
    end else begin
      // Issuer index is carried with the read so rvalid survives a release.
      rvalid_p1 <= (access && !i_we[owner]) ? owner_mask : '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner     <= pick_idx;
            gnt       <= pick_onehot;
            burst_cnt <= '0;
            state     <= OWN;
          end
        end
        OWN: begin
          if (access) begin
            burst_cnt <= sat_inc8(burst_cnt);
          end
          if (release_own) begin
            gnt    <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_gnt    = gnt;
  assign o_rvalid = rvalid_p1;
  assign o_rdata  = i_ram_rdata;
  assign o_busy   = (state == OWN);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_bram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [2:0]  we;
  logic [29:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [7:0]  rdata;
  logic        busy;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  bram_port_arbiter #(
    .N_REQ     (3),
    .ADDR_W    (10),
    .DATA_W    (8),
    .MAX_BURST (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_lock      (lock),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_busy      (busy),
    .o_ram_en    (ram_en),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural BRAM; unwritten locations read as addr[7:0]^0x3C.
  logic [7:0] ram     [1024];
  bit         ram_vld [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram[ram_addr]     <= ram_wdata;
        ram_vld[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= ram_vld[ram_addr] ? ram[ram_addr] : (ram_addr[7:0] ^ 8'h3C);
      end
    end
  end

  typedef struct {
    logic [2:0] gnt;
    logic       en;
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
  } exp_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
  } rd_t;

  exp_t       exp_q[$];
  rd_t        rd_q[$];
  logic [7:0] ref_mem [1024];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t me;
  rd_t  mr;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("gnt", int'(gnt), int'(me.gnt));
      chk("busy", int'(busy), int'(me.gnt != 3'b000));
      chk("ram_en", int'(ram_en), int'(me.en));
      if (me.en) begin
        chk("ram_we", int'(ram_we), int'(me.we));
        chk("ram_addr", int'(ram_addr), int'(me.addr));
        if (me.we) chk("ram_wdata", int'(ram_wdata), int'(me.wdata));
      end else begin
        chk("ram_we_idle", int'(ram_we), 0);
      end
    end
    if (!rst_n) begin
      chk("rst_addr", int'(ram_addr), 0);
      chk("rst_wdata", int'(ram_wdata), 0);
      chk("rst_rvalid", int'(rvalid), 0);
    end
    if (rvalid != 3'b000) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got 0x%0h expected 0x0 (cycle %0d)", rvalid, cyc);
      end else begin
        mr = rd_q.pop_front();
        chk("rvalid_idx", int'(rvalid), 1 << mr.idx);
        chk("rdata", int'(rdata), int'(mr.data));
        chk("rvalid_cycle", cyc, mr.due);
      end
    end
  end

  task automatic step(input logic rv, input logic [2:0] rq, input logic [2:0] lk,
                      input logic [2:0] w, input int who, input logic [9:0] a,
                      input logic [7:0] d, input logic [2:0] eg, input logic ee,
                      input logic mid_rst);
    exp_t e;
    rd_t  r;
    @(posedge clk);
    #1;
    rst_n = rv;
    req   = rq;
    lock  = lk;
    we    = w;
    for (int k = 0; k < 3; k++) begin
      addr[k*10 +: 10] = (k == who) ? a : ~a;
      wdata[k*8 +: 8]  = (k == who) ? d : ~d;
    end
    if (mid_rst) begin
      #2;
      rst_n = 1'b0;
    end
    e.gnt   = eg;
    e.en    = ee;
    e.we    = w[who];
    e.addr  = a;
    e.wdata = d;
    exp_q.push_back(e);
    if (ee) begin
      if (w[who]) begin
        ref_mem[a] = d;
      end else begin
        r.idx  = who;
        r.data = ref_mem[a];
        r.due  = cyc + 1;
        rd_q.push_back(r);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
    rst_n = 1'b0;
    req   = 3'b111;
    lock  = 3'b000;
    we    = 3'b000;
    addr  = '0;
    wdata = '0;

    // Reset held with all requests up, then release: requester 0 wins from pointer 0.
    step(0, 3'b111, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    step(1, 3'b111, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    step(1, 3'b001, 3'b000, 3'b001, 0, 10'h005, 8'hA5, 3'b001, 1, 0);
    step(1, 3'b001, 3'b000, 3'b000, 0, 10'h005, 8'h00, 3'b001, 1, 0);
    step(1, 3'b000, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b001, 0, 0);

    // Requesters 1 and 2 alternate, cap of 4 forces each release.
    step(1, 3'b110, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 3'b110, 3'b000, 3'b010, 1, 10'(16 + i), 8'(17 + i), 3'b010, 1, 0);
    step(1, 3'b110, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, 3'b110, 3'b000, 3'b100, 2, 10'(32 + i), 8'(33 + i), 3'b100, 1, 0);
    step(1, 3'b110, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    step(1, 3'b000, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b010, 0, 0);

    // Locked burst by requester 0 is cut after 4 accesses once requester 2 asks.
    step(1, 3'b001, 3'b001, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    step(1, 3'b001, 3'b001, 3'b000, 0, 10'h005, 8'h00, 3'b001, 1, 0);
    step(1, 3'b101, 3'b001, 3'b000, 0, 10'h010, 8'h00, 3'b001, 1, 0);
    step(1, 3'b101, 3'b001, 3'b000, 0, 10'h020, 8'h00, 3'b001, 1, 0);
    step(1, 3'b101, 3'b001, 3'b000, 0, 10'h011, 8'h00, 3'b001, 1, 0);
    step(1, 3'b101, 3'b001, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    step(1, 3'b000, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b100, 0, 0);

    // Requester 1 locked through a 3-cycle gap; requester 0 waits.
    step(1, 3'b010, 3'b010, 3'b000, 1, 10'h000, 8'h00, 3'b000, 0, 0);
    step(1, 3'b011, 3'b010, 3'b010, 1, 10'h030, 8'h33, 3'b010, 1, 0);
    for (int i = 0; i < 3; i++)
      step(1, 3'b001, 3'b010, 3'b000, 1, 10'h000, 8'h00, 3'b010, 0, 0);
    step(1, 3'b011, 3'b010, 3'b000, 1, 10'h030, 8'h00, 3'b010, 1, 0);
    step(1, 3'b011, 3'b010, 3'b000, 1, 10'h012, 8'h00, 3'b010, 1, 0);
    // Fourth access with requester 0 pending: forced release despite lock.
    step(1, 3'b011, 3'b010, 3'b000, 1, 10'h3FF, 8'h00, 3'b010, 1, 0);
    step(1, 3'b001, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);

    // Asynchronous reset in the middle of requester 0's burst.
    step(1, 3'b001, 3'b001, 3'b001, 0, 10'h040, 8'h44, 3'b001, 1, 0);
    step(1, 3'b001, 3'b001, 3'b000, 0, 10'h005, 8'h00, 3'b000, 0, 1);
    step(0, 3'b110, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    step(1, 3'b110, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    step(1, 3'b000, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b010, 0, 0);
    step(1, 3'b000, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);
    step(1, 3'b000, 3'b000, 3'b000, 0, 10'h000, 8'h00, 3'b000, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reads_outstanding", rd_q.size(), 0);
    chk("trace_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
